// File: rtl/matmul_sequencer.sv
// matmul_sequencer
//   Sequences one N x N signed matrix multiply through an external
//   output-stationary systolic array. A and B rows are loaded into local
//   buffers while idle; on start the array is cleared, fed with skewed edge
//   lanes for 2N-1 cycles, left to propagate for DRAIN_CYC cycles, and the
//   frozen results are then handed out row by row over a valid/ready port.
//
//   Optional build macro: MATMUL_SEQ_PERF_EN adds the perf_cycles output.
//
//   Ports
//     clk, reset            clock (rising edge), async active-high reset
//     wr_en/wr_sel/wr_row   operand row write (sel 0 = A, 1 = B), IDLE only
//     wr_data               row data, lane k = element [row][k]
//     start                 begin a multiply (IDLE only)
//     busy, done            not-IDLE flag, one-cycle completion pulse
//     arr_a, arr_b          skewed edge lanes into the array
//     arr_en, arr_clr       array advance enable / accumulator clear
//     arr_c                 array results, [i][j] at (i*N+j)*CW
//     res_valid/res_ready   result row handshake
//     res_row, res_data     result row index and C[res_row][0..N-1]
//     perf_cycles           (MATMUL_SEQ_PERF_EN) cycles from start to done
//
//   state  | meaning
//   IDLE   | operand loading allowed, waiting for start
//   CLEAR  | one cycle of accumulator clear
//   FEED   | skewed operand injection, k = 0..2N-2
//   DRAIN  | zero lanes while partial sums propagate
//   OUTPUT | array frozen, rows handed out in order
module matmul_sequencer #(
  parameter int N         = 8,
  parameter int DW        = 8,
  parameter int CW        = 16,
  parameter int DRAIN_CYC = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [2:0]        wr_row,
  input  logic [N*DW-1:0]   wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [N*DW-1:0]   arr_a,
  output logic [N*DW-1:0]   arr_b,
  output logic              arr_en,
  output logic              arr_clr,
  input  logic [N*N*CW-1:0] arr_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2:0]        res_row,
  output logic [N*CW-1:0]   res_data
`ifdef MATMUL_SEQ_PERF_EN
  ,
  output logic [15:0]       perf_cycles
`endif
);

  localparam int KW  = $clog2(2*N);
  localparam int DRW = $clog2(DRAIN_CYC+1);
  localparam logic [KW-1:0]  K_LAST   = KW'(2*N-2);
  localparam logic [DRW-1:0] DR_LOAD  = DRW'(DRAIN_CYC-1);
  localparam logic [2:0]     ROW_LAST = 3'(N-1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_FEED   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_OUTPUT = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    feed_k_q, feed_k_d;
  logic [DRW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [2:0]       row_q, row_d;
  logic             done_q, done_d;
  logic [N*DW-1:0]  a_buf_q [N];
  logic [N*DW-1:0]  b_buf_q [N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      feed_k_q    <= '0;
      drain_cnt_q <= '0;
      row_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      feed_k_q    <= feed_k_d;
      drain_cnt_q <= drain_cnt_d;
      row_q       <= row_d;
      done_q      <= done_d;
    end
  end

  // Operand buffers persist across operations so a repeated start reuses them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < N; r++) begin
        a_buf_q[r] <= '0;
        b_buf_q[r] <= '0;
      end
    end else if (wr_en && (state_q == ST_IDLE)) begin
      if (wr_sel) b_buf_q[wr_row] <= wr_data;
      else        a_buf_q[wr_row] <= wr_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    feed_k_d    = feed_k_q;
    drain_cnt_d = drain_cnt_q;
    row_d       = row_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d  = ST_FEED;
        feed_k_d = '0;
      end
      ST_FEED: begin
        if (feed_k_q == K_LAST) begin
          state_d     = ST_DRAIN;
          feed_k_d    = '0;
          drain_cnt_d = DR_LOAD;
        end else begin
          feed_k_d = feed_k_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = ST_OUTPUT;
          row_d   = '0;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      ST_OUTPUT: begin
        if (res_ready) begin
          if (row_q == ROW_LAST) begin
            state_d = ST_IDLE;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = done_q;
    arr_en    = (state_q == ST_FEED) || (state_q == ST_DRAIN);
    arr_clr   = (state_q == ST_CLEAR);
    res_valid = (state_q == ST_OUTPUT);
    res_row   = row_q;
    arr_a     = '0;
    arr_b     = '0;
    res_data  = '0;
    // Lane i carries element m = k-i, so lane skew equals the lane index.
    if (state_q == ST_FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int m = 0; m < N; m++) begin
          if (int'(feed_k_q) == i + m) begin
            arr_a[i*DW +: DW] = a_buf_q[i][m*DW +: DW];
            arr_b[i*DW +: DW] = b_buf_q[m][i*DW +: DW];
          end
        end
      end
    end
    if (state_q == ST_OUTPUT) begin
      for (int i = 0; i < N; i++) begin
        if (row_q == 3'(i)) begin
          for (int j = 0; j < N; j++) begin
            res_data[j*CW +: CW] = arr_c[(i*N+j)*CW +: CW];
          end
        end
      end
    end
  end

`ifdef MATMUL_SEQ_PERF_EN
  // The accepting cycle counts as the first one; the done cycle is the last.
  logic [15:0] perf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      perf_q <= 16'd1;
    end else if ((state_q != ST_IDLE) || done_q) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  // Performance counter not built.
`endif

endmodule
